// File: rtl/reduce_gate_pkg.sv
// Shared constants and helpers for the reduce_gate_capture block.
package reduce_gate_pkg;

   localparam int unsigned MODE_OR  = 0;
   localparam int unsigned MODE_AND = 1;
   localparam int unsigned MODE_XOR = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

   // Width of the Index output: never narrower than one bit.
   function automatic int unsigned index_width(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/reduce_sync_chain.sv
// N-bit multi-flop synchroniser with clock enable; zero stages is a pass-through.
module reduce_sync_chain
   import reduce_gate_pkg::*;
#(
   parameter int unsigned WIDTH  = 9,
   parameter int unsigned STAGES = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] synced
);

   if (STAGES == 0) begin : g_bypass
      assign synced = raw;
   end else begin : g_chain
      logic [WIDTH-1:0] stage_p0 [STAGES];

      // Shift the raw vector through the flop chain on enabled edges.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) stage_p0[i] <= '0;
         end else if (en) begin
            stage_p0[0] <= raw;
            for (int i = 1; i < int'(STAGES); i++) stage_p0[i] <= stage_p0[i-1];
         end
      end

      assign synced = stage_p0[STAGES-1];
   end

endmodule

// File: rtl/reduce_gate_capture.sv
// Bubble-masked request vector -> optional sync -> level or sticky edge capture
// -> registered AND/OR/XOR reduction, rise pulse, any-active and lowest index.
module reduce_gate_capture
   import reduce_gate_pkg::*;
#(
   parameter int unsigned           NrOfInputs  = 9,
   parameter logic [NrOfInputs-1:0] BubblesMask = '0,
   parameter int unsigned           Mode        = MODE_OR,
   parameter int unsigned           SyncStages  = 2,
   parameter bit                    Sticky      = 1'b0,
   localparam int unsigned          IW          = index_width(NrOfInputs)
)(
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  ClockEnable,
   input  logic [NrOfInputs-1:0] Inputs,
   input  logic [NrOfInputs-1:0] Clear,
   output logic                  Result,
   output logic                  Rise,
   output logic                  AnyActive,
   output logic [IW-1:0]         Index
);

   if (NrOfInputs < 1 || NrOfInputs > 32) begin : g_bad_width
      $error("reduce_gate_capture: NrOfInputs must be 1..32");
   end
   if (Mode > MODE_XOR) begin : g_bad_mode
      $error("reduce_gate_capture: Mode must be 0 (OR), 1 (AND) or 2 (XOR)");
   end
   if (SyncStages > 3) begin : g_bad_sync
      $error("reduce_gate_capture: SyncStages must be 0..3");
   end

   function automatic logic reduce_vec(input logic [NrOfInputs-1:0] v);
      case (Mode)
         MODE_AND: return &v;
         MODE_XOR: return ^v;
         default:  return |v;
      endcase
   endfunction

   logic [NrOfInputs-1:0] masked;
   logic [NrOfInputs-1:0] synced_p0;
   logic [NrOfInputs-1:0] prev_p1;
   logic [NrOfInputs-1:0] pending_p1;
   logic [NrOfInputs-1:0] rise_vec;
   logic [NrOfInputs-1:0] state;
   logic                  result_next;
   logic [IW-1:0]         index_next;
   logic                  result_p2;
   logic                  rise_p2;
   logic                  any_p2;
   logic [IW-1:0]         index_p2;

   assign masked = Inputs ^ BubblesMask;

   reduce_sync_chain #(
      .WIDTH  (NrOfInputs),
      .STAGES (SyncStages)
   ) u_sync (
      .clk    (Clock),
      .rst_n  (Reset_n),
      .en     (ClockEnable),
      .raw    (masked),
      .synced (synced_p0)
   );

   // ---- stage p1: edge detect and sticky pending capture ----
   assign rise_vec = synced_p0 & ~prev_p1;

   // Remember last synced value; fold rising edges into pending, set beats Clear.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         prev_p1    <= '0;
         pending_p1 <= '0;
      end else if (ClockEnable) begin
         prev_p1    <= synced_p0;
         pending_p1 <= (pending_p1 & ~Clear) | rise_vec;
      end
   end

   assign state = Sticky ? pending_p1 : synced_p0;

   // ---- stage p2: reduction, any-active and lowest-index encode ----
   // Priority encode: scanning downwards lets the lowest set bit win.
   always_comb begin
      result_next = reduce_vec(state);
      index_next  = '0;
      for (int i = int'(NrOfInputs) - 1; i >= 0; i--) begin
         if (state[i]) index_next = IW'(i);
      end
   end

   // Registered outputs; the rise pulse is dropped on disabled edges.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         result_p2 <= 1'b0;
         rise_p2   <= 1'b0;
         any_p2    <= 1'b0;
         index_p2  <= '0;
      end else if (ClockEnable) begin
         result_p2 <= result_next;
         rise_p2   <= result_next & ~result_p2;
         any_p2    <= |state;
         index_p2  <= index_next;
      end else begin
         rise_p2   <= 1'b0;
      end
   end

   assign Result    = result_p2;
   assign Rise      = rise_p2 & ClockEnable;
   assign AnyActive = any_p2;
   assign Index     = index_p2;

endmodule
